rx_clk_divider: RTL and testbench
=================================

# rx_clk_divider

- Integer clock divider that consumes the divide ratio produced by the RX prescale mux and generates the UART RX sampling clock from the reference clock.
- Even ratios give a 50% duty cycle. Odd ratios give a (N+1)/2 low phase and a (N−1)/2 high phase.
- Ratios 0 and 1, or a disabled divider, pass the reference clock straight through.
- Sits between the prescale mux and the UART RX clock tree in the RX clock domain.

## Interface

- RATIO_WD, 8, width of the divide-ratio input; matches the mux output width.
- i_ref_clk  input  1  reference clock; the only clock in the block.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_clk_en  input  1  divider enable; low forces bypass.
- i_div_ratio  input  RATIO_WD  requested divide ratio N, unsigned.
- o_div_clk  output  1  divided clock, or i_ref_clk when in bypass.

## Operation

- Internal registers:
  - cnt (RATIO_WD−1 bits): phase counter.
  - div_q: divided-clock flop.
  - ratio_q (RATIO_WD bits): shadow copy of the active ratio.
- Mode is decided by a combinational flag, div_act = i_clk_en && (ratio_q >= 2).
  - div_act = 0 selects bypass: o_div_clk = i_ref_clk.
  - div_act = 1 selects divide: o_div_clk = div_q.
- Reset (i_rst_n low at a rising edge):
  - cnt = 0, div_q = 0, ratio_q = 0.
  - o_div_clk is therefore in bypass while reset is held and until ratio_q loads.
- In bypass:
  - ratio_q loads i_div_ratio every cycle.
  - cnt and div_q are held at 0.
- Divide phases:
  - LOW phase (div_q = 0) lasts ceil(N/2) cycles.
  - HIGH phase (div_q = 1) lasts floor(N/2) cycles.
  - N = ratio_q.
- Phase transitions:
  - In LOW, when cnt == ceil(N/2)−1: div_q goes to 1 and cnt goes to 0. Otherwise cnt increments.
  - In HIGH, when cnt == floor(N/2)−1: div_q goes to 0 and cnt goes to 0. This is the period boundary.
  - Otherwise cnt increments.
- Arithmetic:
  - ceil(N/2) = (N>>1) + N[0]; floor(N/2) = N>>1.
  - Both are computed in RATIO_WD bits, so no overflow occurs.
  - Maximum ratio is 2^RATIO_WD − 1.
- i_clk_en falling while in divide:
  - Bypass takes effect immediately (combinational).
  - cnt and div_q clear at the next edge.
- i_clk_en rising: divide starts with a full LOW phase. The first divided rising edge comes ceil(N/2) cycles after the first enabled edge.
- Reset asserted mid-period: reset wins over every other update. The block returns to bypass on the same edge.

## Timing

- Latency from a new ratio in bypass to the start of division:
  - 1 cycle for ratio_q to load.
  - Then the LOW phase of ceil(N/2) cycles.
- Output period in divide mode is exactly N i_ref_clk cycles. Edges of div_q are aligned to rising edges of i_ref_clk.
- A ratio change while dividing takes effect as defined under Configuration.
- N = 2: div_q toggles every cycle.
- N = 3: LOW 2 cycles, HIGH 1 cycle.

## Configuration

- Macro: RX_CLKDIV_GLITCHLESS_EN.
- Defined:
  - While div_act = 1, ratio_q loads i_div_ratio only at the period boundary (the HIGH→LOW transition).
  - An in-flight period always completes with the old ratio, so no runt pulses occur.
  - If the new ratio is < 2, bypass starts right after that boundary.
- Undefined:
  - While div_act = 1, ratio_q loads i_div_ratio on any cycle where they differ.
  - On that same edge cnt and div_q clear to 0, restarting a LOW phase.
  - A shortened phase is permitted in this mode.

## Test plan

- Reset, then en=1, ratio=4 → o_div_clk = i_ref_clk during reset and for the 1 load cycle, then a steady 2 low / 2 high pattern (period 4).
- en=1, ratio=5 → low 3 cycles, high 2 cycles, period 5, repeated over 20 periods.
- ratio=1 and ratio=0, en=1 → o_div_clk identical to i_ref_clk on every cycle; ratio=8 with en=0 → bypass.
- ratio=8, change to 2 in the middle of a HIGH phase:
  - With the macro: the current 8-cycle period completes, then period 2 begins.
  - Without the macro: div_q drops on the next edge, then period 2 begins.
- ratio=255 (max) → low 128 cycles, high 127 cycles, no counter wrap.
- ratio=6, deassert i_rst_n for 1 cycle mid-LOW → bypass on that edge; after release, a fresh 3/3 pattern starts 1 + 3 cycles later.

Source files
------------

// File: rtl/rx_clk_divider.sv
// -----------------------------------------------------------------------------
// rx_clk_divider
//
// Integer clock divider for the UART RX sampling clock. Takes the divide ratio
// N from the RX prescale mux and divides i_ref_clk by N:
//   - even N : 50% duty cycle
//   - odd N  : LOW for (N+1)/2 cycles, HIGH for (N-1)/2 cycles
//   - N < 2, or i_clk_en low : i_ref_clk passes straight through (bypass)
//
// Ports:
//   i_ref_clk   : reference clock, the only clock in the block
//   i_rst_n     : synchronous, active-low reset
//   i_clk_en    : divider enable; low forces bypass
//   i_div_ratio : requested divide ratio N (unsigned, RATIO_WD bits)
//   o_div_clk   : divided clock, or i_ref_clk in bypass
//
// Build option:
//   RX_CLKDIV_GLITCHLESS_EN
//     defined   - a ratio change while dividing is taken only at the period
//                 boundary (HIGH->LOW), so the running period always completes.
//     undefined - a ratio change while dividing is taken at once and restarts
//                 a LOW phase; a shortened phase can appear on o_div_clk.
// -----------------------------------------------------------------------------
module rx_clk_divider #(
  parameter int RATIO_WD = 8
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk
);

  localparam int CNT_WD = RATIO_WD - 1;
  localparam logic [RATIO_WD-1:0] ONE_R = {{(RATIO_WD-1){1'b0}}, 1'b1};
  localparam logic [CNT_WD-1:0]   ONE_C = {{(CNT_WD-1){1'b0}}, 1'b1};

  logic [CNT_WD-1:0]   cnt_q,   cnt_d;
  logic                div_q,   div_d;
  logic [RATIO_WD-1:0] ratio_q, ratio_d;

  logic                div_act;
  logic [RATIO_WD-1:0] half_lo;   // ceil(N/2): LOW phase length
  logic [RATIO_WD-1:0] half_hi;   // floor(N/2): HIGH phase length
  logic                phase_end;

  // Divide mode only when enabled and the shadowed ratio really divides.
  assign div_act = i_clk_en && (ratio_q >= RATIO_WD'(2));

  assign half_hi = ratio_q >> 1;
  assign half_lo = (ratio_q >> 1) + {{(RATIO_WD-1){1'b0}}, ratio_q[0]};

  // The LOW phase is at most 2^(RATIO_WD-1) cycles, so its last count fits in
  // RATIO_WD-1 bits; compare against the zero-extended counter.
  always_comb begin
    if (div_q) begin
      phase_end = ({1'b0, cnt_q} == (half_hi - ONE_R));
    end else begin
      phase_end = ({1'b0, cnt_q} == (half_lo - ONE_R));
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    ratio_d = ratio_q;

    if (!div_act) begin
      // Bypass: track the requested ratio, park the phase logic at LOW/0.
      ratio_d = i_div_ratio;
      cnt_d   = '0;
      div_d   = 1'b0;
    end else begin
      if (phase_end) begin
        cnt_d = '0;
        div_d = ~div_q;
      end else begin
        cnt_d = cnt_q + ONE_C;
      end

`ifdef RX_CLKDIV_GLITCHLESS_EN
      // End of HIGH is the period boundary: the only safe point to retarget.
      if (div_q && phase_end) begin
        ratio_d = i_div_ratio;
      end
`else
      // Retarget immediately and restart from the beginning of a LOW phase.
      if (i_div_ratio != ratio_q) begin
        ratio_d = i_div_ratio;
        cnt_d   = '0;
        div_d   = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      div_q   <= 1'b0;
      ratio_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ratio_q <= ratio_d;
    end
  end

  // Bypass switches combinationally so a falling enable takes effect at once.
  assign o_div_clk = div_act ? div_q : i_ref_clk;

endmodule

// File: tb/tb_rx_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_rx_clk_divider
//
// Drives rx_clk_divider with directed sequences followed by random ratio /
// enable / reset segments. Inputs change 2 time units after each falling edge
// of i_ref_clk, so every reference cycle sees stable inputs. o_div_clk is
// sampled once while i_ref_clk is high and once while it is low; in bypass
// those samples read 1/0, in divide mode both read the divided level.
//
// The reference model describes the divider as a position within an N-cycle
// period: positions 0 .. ceil(N/2)-1 are LOW, the rest HIGH.
// -----------------------------------------------------------------------------
module tb_rx_clk_divider;

  localparam int RATIO_WD = 8;

  // ---------------------------------------------------------------- clock/reset
  logic                i_ref_clk = 1'b0;
  logic                i_rst_n;
  logic                i_clk_en;
  logic [RATIO_WD-1:0] i_div_ratio;
  logic                o_div_clk;

  always #5 i_ref_clk = ~i_ref_clk;

  rx_clk_divider #(.RATIO_WD(RATIO_WD)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst_n    (i_rst_n),
    .i_clk_en   (i_clk_en),
    .i_div_ratio(i_div_ratio),
    .o_div_clk  (o_div_clk)
  );

  // ---------------------------------------------------------------- scoreboard
  // Each entry: {sample while i_ref_clk high, sample while i_ref_clk low}.
  logic [1:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  // Reference model state.
  int m_ratio = 0;
  int m_pos   = 0;

  function automatic logic [1:0] model_step(input logic r, input logic e,
                                            input int n);
    logic act;
    logic lvl;
    act = e && (m_ratio >= 2);
    if (!r) begin
      m_ratio = 0;
      m_pos   = 0;
    end else if (!act) begin
      m_ratio = n;
      m_pos   = 0;
    end else begin
`ifdef RX_CLKDIV_GLITCHLESS_EN
      if (m_pos == m_ratio - 1) begin
        m_pos   = 0;
        m_ratio = n;
      end else begin
        m_pos = m_pos + 1;
      end
`else
      if (n != m_ratio) begin
        m_ratio = n;
        m_pos   = 0;
      end else begin
        m_pos = (m_pos + 1) % m_ratio;
      end
`endif
    end
    act = e && (m_ratio >= 2);
    lvl = (m_pos >= (m_ratio + 1) / 2);
    return act ? {lvl, lvl} : 2'b10;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic apply(input logic r, input logic e, input int n);
    i_rst_n     = r;
    i_clk_en    = e;
    i_div_ratio = n[RATIO_WD-1:0];
    exp_q.push_back(model_step(r, e, n));
  endtask

  task automatic step(input logic r, input logic e, input int n, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_ref_clk);
      #2;
      apply(r, e, n);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    logic       s_hi;
    logic       s_lo;
    logic [1:0] exp;
    forever begin
      @(posedge i_ref_clk);
      #1 s_hi = o_div_clk;
      @(negedge i_ref_clk);
      #1 s_lo = o_div_clk;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if ({s_hi, s_lo} !== exp) begin
          n_fail++;
          $display("FAIL o_div_clk cycle %0d: got hi/lo=%b%b required %b%b",
                   cyc, s_hi, s_lo, exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    int ratio;
    int len;
    logic en;
    int waited;

    // Reset held for 3 edges, then ratio 4.
    apply(1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 4, 2);
    step(1'b1, 1'b1, 4, 16);

    // Odd ratio, 20 periods.
    step(1'b1, 1'b1, 5, 100);

    // Bypass cases.
    step(1'b1, 1'b1, 1, 10);
    step(1'b1, 1'b1, 0, 10);
    step(1'b1, 1'b0, 8, 10);

    // Ratio 8, retarget to 2 during the HIGH phase.
    step(1'b1, 1'b1, 8, 6);
    step(1'b1, 1'b1, 2, 20);

    // Maximum ratio.
    step(1'b1, 1'b1, 255, 600);

    // Reset pulse in the middle of a LOW phase.
    step(1'b1, 1'b1, 6, 8);
    step(1'b0, 1'b1, 6, 1);
    step(1'b1, 1'b1, 6, 20);

    // Enable dropping mid-period then returning.
    step(1'b1, 1'b1, 7, 5);
    step(1'b1, 1'b0, 7, 2);
    step(1'b1, 1'b1, 7, 20);

    // Random segments.
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        ratio = $urandom_range(0, 255);
      end else begin
        ratio = $urandom_range(0, 12);
      end
      en  = ($urandom_range(0, 5) != 0);
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 15) == 0) begin
        step(1'b0, en, ratio, 1);
      end
      step(1'b1, en, ratio, len);
    end

    // Let the monitor drain what is still queued.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge i_ref_clk);
      waited++;
    end
    @(negedge i_ref_clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
